// File: rtl/matvec_pkg.sv
// matvec_pkg: shared FSM state codes and helpers for the matvec_array layer.
//   state_t / S_*   : controller state encoding (IDLE, MAC, WRITE, DONE)
//   ceil_div        : group count for LANES-wide row groups
//   clog2_min1      : index width, never zero
//   sat_to_out      : clamp a wide signed sum into an OUTBITS-wide signed range
package matvec_pkg;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_MAC   = 2'd1;
  localparam state_t S_WRITE = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  function automatic int ceil_div(input int a, input int d);
    return (a + d - 1) / d;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // v carries the ACC_BITS+1 sum sign-extended to 64 bits.
  function automatic longint sat_to_out(input longint v, input int outbits);
    longint hi, lo;
    hi = (longint'(1) <<< (outbits - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/matvec_lane.sv
// matvec_lane: one row's multiply-accumulate datapath.
//   clk, reset  : clock, synchronous active-high reset (clears acc)
//   clr_i       : clear accumulator (takes priority over acc_en_i)
//   acc_en_i    : acc += x_i * m_i
//   x_i, m_i    : signed BITS operands
//   b_i         : signed OUTBITS bias for this row
//   res_o       : sat(acc + b_i), combinational from the accumulator
// Build option: MATVEC_RELU_EN clamps negative results to zero.
module matvec_lane
  import matvec_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int OUTBITS  = 24,
  parameter int ACC_BITS = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr_i,
  input  logic                      acc_en_i,
  input  logic signed [BITS-1:0]    x_i,
  input  logic signed [BITS-1:0]    m_i,
  input  logic signed [OUTBITS-1:0] b_i,
  output logic signed [OUTBITS-1:0] res_o
);

  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic signed [2*BITS-1:0]   prod;
  logic signed [ACC_BITS:0]   sum;
  logic signed [OUTBITS-1:0]  sat;

  assign prod = x_i * m_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)         acc_d = '0;
    else if (acc_en_i) acc_d = acc_q + ACC_BITS'(prod);
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // One extra bit so acc + b cannot wrap before the clamp.
  assign sum = (ACC_BITS+1)'(acc_q) + (ACC_BITS+1)'(b_i);
  assign sat = OUTBITS'(sat_to_out(longint'(sum), OUTBITS));

`ifdef MATVEC_RELU_EN
  assign res_o = sat[OUTBITS-1] ? '0 : sat;
`else
  assign res_o = sat;
`endif

endmodule

// File: rtl/matvec_array.sv
// matvec_array: y = sat(M*x + b), LANES rows per group, one column per cycle.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a run (sampled only in IDLE)
//   x, M, b    : operands, must stay stable while busy (M is row-major)
//   y          : registered results, each row updated at its group's WRITE
//   busy       : high from the cycle after start is accepted through DONE
//   done       : one-cycle pulse once every row of y is written
// Build option: MATVEC_RELU_EN stores max(result, 0) (handled in matvec_lane).
module matvec_array
  import matvec_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int OUTBITS     = 24,
  parameter int ACC_BITS    = 32,
  parameter int ROW_SIZE    = 10,
  parameter int COLUMN_SIZE = 10,
  parameter int LANES       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [BITS-1:0]    x [ROW_SIZE],
  input  logic signed [BITS-1:0]    M [ROW_SIZE*COLUMN_SIZE],
  input  logic signed [OUTBITS-1:0] b [COLUMN_SIZE],
  output logic signed [OUTBITS-1:0] y [COLUMN_SIZE],
  output logic                      busy,
  output logic                      done
);

  localparam int G  = ceil_div(COLUMN_SIZE, LANES);
  localparam int KW = clog2_min1(ROW_SIZE);
  localparam int GW = clog2_min1(G);
  localparam int RW = clog2_min1(COLUMN_SIZE);
  localparam int MW = clog2_min1(ROW_SIZE*COLUMN_SIZE);

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [GW-1:0]  g_q, g_d;

  logic signed [OUTBITS-1:0]       y_q [COLUMN_SIZE];
  logic [LANES-1:0]                lane_ok;
  logic [LANES-1:0][RW-1:0]        lane_row;
  logic [LANES-1:0][OUTBITS-1:0]   lane_res;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    g_d     = g_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_MAC;
        k_d     = '0;
        g_d     = '0;
      end
      S_MAC: begin
        if (k_q == KW'(ROW_SIZE-1)) state_d = S_WRITE;
        else                        k_d     = k_q + 1'b1;
      end
      S_WRITE: begin
        k_d = '0;
        if (g_q == GW'(G-1)) state_d = S_DONE;
        else begin
          state_d = S_MAC;
          g_d     = g_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      g_q     <= g_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int                        row_l;
    logic [MW-1:0]             m_idx;
    logic signed [BITS-1:0]    m_l;
    logic signed [OUTBITS-1:0] b_l;
    logic signed [OUTBITS-1:0] res_l;

    // Lanes past the last row on a partial group see zero operands and
    // are masked out of the y update.
    assign row_l       = int'(g_q) * LANES + l;
    assign lane_ok[l]  = (row_l < COLUMN_SIZE);
    assign lane_row[l] = RW'(row_l);
    assign m_idx       = MW'(row_l * ROW_SIZE + int'(k_q));
    assign m_l         = lane_ok[l] ? M[m_idx] : '0;
    assign b_l         = lane_ok[l] ? b[lane_row[l]] : '0;

    matvec_lane #(
      .BITS(BITS), .OUTBITS(OUTBITS), .ACC_BITS(ACC_BITS)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (state_q == S_WRITE),
      .acc_en_i (state_q == S_MAC),
      .x_i      (x[k_q]),
      .m_i      (m_l),
      .b_i      (b_l),
      .res_o    (res_l)
    );

    assign lane_res[l] = res_l;
  end

  // Result capture and accumulator clear share the WRITE edge; the lane
  // output still reflects the pre-clear accumulator when y samples it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COLUMN_SIZE; i++) y_q[i] <= '0;
    end else if (state_q == S_WRITE) begin
      for (int l = 0; l < LANES; l++)
        if (lane_ok[l]) y_q[lane_row[l]] <= lane_res[l];
    end
  end

  assign y    = y_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_matvec_array.sv
module tb_matvec_array;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: R=4, C=4, L=2, 24-bit outputs.
  logic                start_a;
  logic signed [7:0]   xa [4];
  logic signed [7:0]   Ma [16];
  logic signed [23:0]  ba [4];
  logic signed [23:0]  ya [4];
  logic                busy_a, done_a;

  // Instance B: R=4, C=5, L=2 (partial last group), 16-bit outputs.
  logic                start_b;
  logic signed [7:0]   xb [4];
  logic signed [7:0]   Mb [20];
  logic signed [15:0]  bb [5];
  logic signed [15:0]  yb [5];
  logic                busy_b, done_b;

  matvec_array #(.BITS(8), .OUTBITS(24), .ACC_BITS(32), .ROW_SIZE(4),
                 .COLUMN_SIZE(4), .LANES(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .x(xa), .M(Ma), .b(ba),
    .y(ya), .busy(busy_a), .done(done_a));

  matvec_array #(.BITS(8), .OUTBITS(16), .ACC_BITS(32), .ROW_SIZE(4),
                 .COLUMN_SIZE(5), .LANES(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .x(xb), .M(Mb), .b(bb),
    .y(yb), .busy(busy_b), .done(done_b));

  int n_chk = 0;
  int n_fail = 0;

  // Current stimulus, shared by whichever instance is being exercised.
  int qx[$], qm[$], qb[$];

  typedef struct {
    int x[4];
    int m[16];
    int b[4];
    int e[4];   // saturated result before the optional ReLU
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int post(input int v);
`ifdef MATVEC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: dot product in plain 64-bit arithmetic, clamp, optional ReLU.
  function automatic int ref_y(input int r, input int ob, input int row);
    longint s, hi, lo;
    s = qb[row];
    for (int c = 0; c < r; c++) s += longint'(qx[c]) * longint'(qm[row*r + c]);
    hi = (longint'(1) <<< (ob - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return post(int'(s));
  endfunction

  task automatic apply_a();
    for (int i = 0; i < 4; i++)  xa[i] = 8'(qx[i]);
    for (int i = 0; i < 16; i++) Ma[i] = 8'(qm[i]);
    for (int i = 0; i < 4; i++)  ba[i] = 24'(qb[i]);
  endtask

  task automatic apply_b();
    for (int i = 0; i < 4; i++)  xb[i] = 8'(qx[i]);
    for (int i = 0; i < 20; i++) Mb[i] = 8'(qm[i]);
    for (int i = 0; i < 5; i++)  bb[i] = 16'(qb[i]);
  endtask

  task automatic fill(input int n, input int lo, input int hi, output int q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(hi - lo)) + lo);
  endtask

  // One start pulse; checks latency, busy throughout, and a one-cycle done.
  task automatic run(input bit sel, input int exp_lat, input string nm);
    int cnt = 0;
    bit got = 0, bsy_ok = 1;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    if (!(sel ? busy_b : busy_a)) bsy_ok = 0;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    while (!got && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (sel ? done_b : done_a) got = 1;
      if (!(sel ? busy_b : busy_a)) bsy_ok = 0;
    end
    chk({nm, " done latency"}, cnt, exp_lat);
    chk({nm, " busy during run"}, bsy_ok, 1);
    @(posedge clk); #1;
    chk({nm, " done one cycle"}, sel ? done_b : done_a, 0);
    chk({nm, " busy after done"}, sel ? busy_b : busy_a, 0);
  endtask

  initial begin
    int d[23], bz[23], npulse;

    tbl[0].x = '{1, 2, 3, 4};
    tbl[0].m = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
    tbl[0].b = '{10, 20, 30, 40};
    tbl[0].e = '{11, 22, 33, 44};
    tbl[1].x = '{1, 2, 3, 4};
    tbl[1].m = '{-1,0,0,0, 0,-1,0,0, 0,0,-1,0, 0,0,0,-1};
    tbl[1].b = '{0, 0, 0, 0};
    tbl[1].e = '{-1, -2, -3, -4};
    tbl[2].x = '{2, -3, 5, -7};
    tbl[2].m = '{1,1,1,1, 1,-1,1,-1, 0,0,0,0, 127,127,127,127};
    tbl[2].b = '{100, -20, -5, 1000};
    tbl[2].e = '{97, -3, -5, 619};
    tbl[3].x = '{127, 127, 127, 127};
    tbl[3].m = '{127,127,127,127, -128,-128,-128,-128,
                 127,127,127,127, -128,-128,-128,-128};
    tbl[3].b = '{8388600, -8388608, 0, 0};
    tbl[3].e = '{8388607, -8388608, 64516, -65024};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    qx = '{0,0,0,0}; qm.delete(); qb.delete();
    for (int i = 0; i < 20; i++) qm.push_back(0);
    for (int i = 0; i < 5; i++)  qb.push_back(0);
    apply_a(); apply_b();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("reset ya%0d", i), ya[i], 0);
    chk("reset yb4", yb[4], 0);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    @(negedge clk) reset = 1'b0;

    // Directed table on A: 2 groups x (4+1) cycles.
    for (int t = 0; t < 4; t++) begin
      qx.delete(); qm.delete(); qb.delete();
      for (int i = 0; i < 4; i++)  qx.push_back(tbl[t].x[i]);
      for (int i = 0; i < 16; i++) qm.push_back(tbl[t].m[i]);
      for (int i = 0; i < 4; i++)  qb.push_back(tbl[t].b[i]);
      apply_a();
      run(1'b0, 10, $sformatf("tbl%0d", t));
      for (int i = 0; i < 4; i++)
        chk($sformatf("tbl%0d y%0d", t, i), ya[i], post(tbl[t].e[i]));
    end

    // Randomized on A; every third vector pushes the bias toward a rail.
    for (int n = 0; n < 12; n++) begin
      fill(4, -128, 127, qx);
      fill(16, -128, 127, qm);
      if (n % 3 == 0) begin
        qb.delete();
        for (int i = 0; i < 4; i++)
          qb.push_back((i % 2 ? -1 : 1) * (8388607 - int'($urandom_range(70000))));
      end else fill(4, -8388608, 8388607, qb);
      apply_a();
      run(1'b0, 10, $sformatf("randA%0d", n));
      for (int i = 0; i < 4; i++)
        chk($sformatf("randA%0d y%0d", n, i), ya[i], ref_y(4, 24, i));
    end

    // B: partial last group, 3 groups x 5 cycles.
    qx = '{1,1,1,1}; qm.delete(); qb.delete();
    for (int i = 0; i < 20; i++) qm.push_back(1);
    for (int i = 0; i < 5; i++)  qb.push_back(0);
    apply_b();
    run(1'b1, 15, "ones");
    for (int i = 0; i < 5; i++) chk($sformatf("ones y%0d", i), yb[i], 4);

    // B: 16-bit saturation at both rails.
    qx = '{127,127,127,127}; qm.delete(); qb.delete();
    for (int i = 0; i < 20; i++) qm.push_back(127);
    for (int i = 0; i < 5; i++)  qb.push_back(32767);
    apply_b();
    run(1'b1, 15, "satpos");
    for (int i = 0; i < 5; i++) chk($sformatf("satpos y%0d", i), yb[i], post(32767));
    qm.delete(); qb.delete();
    for (int i = 0; i < 20; i++) qm.push_back(-128);
    for (int i = 0; i < 5; i++)  qb.push_back(-32768);
    apply_b();
    run(1'b1, 15, "satneg");
    for (int i = 0; i < 5; i++) chk($sformatf("satneg y%0d", i), yb[i], post(-32768));

    for (int n = 0; n < 6; n++) begin
      fill(4, -128, 127, qx);
      fill(20, -128, 127, qm);
      fill(5, -32768, 32767, qb);
      apply_b();
      run(1'b1, 15, $sformatf("randB%0d", n));
      for (int i = 0; i < 5; i++)
        chk($sformatf("randB%0d y%0d", n, i), yb[i], ref_y(4, 16, i));
    end

    // start held high on A: back-to-back runs with one IDLE cycle between.
    qx.delete(); qm.delete(); qb.delete();
    for (int i = 0; i < 4; i++)  qx.push_back(tbl[2].x[i]);
    for (int i = 0; i < 16; i++) qm.push_back(tbl[2].m[i]);
    for (int i = 0; i < 4; i++)  qb.push_back(tbl[2].b[i]);
    apply_a();
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1;
    npulse = 0;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      d[c] = done_a; bz[c] = busy_a;
      npulse += done_a;
    end
    @(negedge clk) start_a = 1'b0;
    chk("held done@9", d[9], 0);
    chk("held done@10", d[10], 1);
    chk("held busy@11", bz[11], 0);
    chk("held busy@12", bz[12], 1);
    chk("held done@22", d[22], 1);
    chk("held pulses", npulse, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("held idle after", busy_a, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("held y%0d", i), ya[i], ref_y(4, 24, i));

    // Reset three cycles into MAC, then a clean rerun.
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    @(negedge clk) start_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk($sformatf("midrst y%0d", i), ya[i], 0);
    chk("midrst busy", busy_a, 0);
    chk("midrst done", done_a, 0);
    @(negedge clk) reset = 1'b0;
    run(1'b0, 10, "postrst");
    for (int i = 0; i < 4; i++) chk($sformatf("postrst y%0d", i), ya[i], ref_y(4, 24, i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
